// File: rtl/gf180mcu_fd_sc_mcu9t5v0__icgen_pkg.sv
// Shared definitions for the icgtn enable sequencer.
// Contents:
//   icgen_state_e  sequencer states RUN / DRAIN / OFF / WAKE
//   IDLE_W_DEF     default idle counter width
//   WAKE_DLY_MAX   largest supported gated-clock settle delay
//   SETTLE_W       width of the settle counter, sized for WAKE_DLY_MAX
//   STATS_W        width of the optional gate-event counter
package gf180mcu_fd_sc_mcu9t5v0__icgen_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    OFF   = 2'd2,
    WAKE  = 2'd3
  } icgen_state_e;

  localparam int IDLE_W_DEF   = 4;
  localparam int WAKE_DLY_MAX = 7;
  localparam int SETTLE_W     = 3;
  localparam int STATS_W      = 8;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__icgen_seq_if.sv
// Control/status bundle between block-level logic and the enable sequencer.
// Signals:
//   BUSY         downstream logic active this cycle
//   WAKE_REQ     level request to ungate, held until WAKE_ACK
//   SCAN_EN      scan/test mode
//   IDLE_THRESH  idle cycles required before gating, 0 = never gate
//   E            functional enable to the icgtn
//   TE           test enable to the icgtn
//   WAKE_ACK     gated clock running and stable
//   GATED        clock currently gated off
// Modports: master = block side driving requests, slave = the sequencer.
interface gf180mcu_fd_sc_mcu9t5v0__icgen_seq_if
  import gf180mcu_fd_sc_mcu9t5v0__icgen_pkg::*;
#(
  parameter int IDLE_W = IDLE_W_DEF
);

  logic              BUSY;
  logic              WAKE_REQ;
  logic              SCAN_EN;
  logic [IDLE_W-1:0] IDLE_THRESH;
  logic              E;
  logic              TE;
  logic              WAKE_ACK;
  logic              GATED;

  modport master (
    output BUSY, WAKE_REQ, SCAN_EN, IDLE_THRESH,
    input  E, TE, WAKE_ACK, GATED
  );

  modport slave (
    input  BUSY, WAKE_REQ, SCAN_EN, IDLE_THRESH,
    output E, TE, WAKE_ACK, GATED
  );

endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__icgen_satcnt.sv
// Generic saturating up-counter with synchronous clear.
// Ports:
//   CLK  clock, updates on posedge
//   clr  synchronous clear, wins over inc
//   inc  count up by one; holds once all ones is reached
//   cnt  current count
module gf180mcu_fd_sc_mcu9t5v0__icgen_satcnt
  import gf180mcu_fd_sc_mcu9t5v0__icgen_pkg::*;
#(
  parameter int W = IDLE_W_DEF
) (
  input  logic         CLK,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Clear first, then count up unless already pinned at the top value.
  always_ff @(posedge CLK) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__icgen_seq.sv
// Enable sequencer for a negative-edge integrated clock gate (icgtn).
// Runs in the always-on domain on the ungated clock. Drops E after
// IDLE_THRESH quiet cycles, brings it back on BUSY or WAKE_REQ and raises
// WAKE_ACK once the gated clock has had WAKE_DLY cycles to settle.
// Ports:
//   CLK       ungated source clock, all state changes on posedge
//   RST       synchronous active-high reset, overrides every input
//   bus       slave side of the sequencer control/status bundle
//   GATE_CNT  saturating count of gating events (stats build only)
// Parameters:
//   IDLE_W    width of the idle counter and IDLE_THRESH
//   WAKE_DLY  settle cycles from E rise to WAKE_ACK, 1..7
// Build option:
//   GF180MCU_ICGEN_SEQ_STATS_EN adds the GATE_CNT output and its counter.
module gf180mcu_fd_sc_mcu9t5v0__icgen_seq
  import gf180mcu_fd_sc_mcu9t5v0__icgen_pkg::*;
#(
  parameter int IDLE_W   = IDLE_W_DEF,
  parameter int WAKE_DLY = 2
) (
  input  logic                CLK,
  input  logic                RST,
`ifdef GF180MCU_ICGEN_SEQ_STATS_EN
  output logic [STATS_W-1:0]  GATE_CNT,
`endif
  gf180mcu_fd_sc_mcu9t5v0__icgen_seq_if.slave bus
);

  icgen_state_e        state;
  logic                e_q;
  logic                te_q;
  logic                ack_q;
  logic                gated_q;
  logic [IDLE_W-1:0]   thresh;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                active;
  logic                drain_hit;
  logic                wake_done;
  logic                idle_clr;
  logic                idle_inc;
  logic                settle_clr;
  logic                settle_inc;

  assign thresh = bus.IDLE_THRESH;
  assign active = bus.BUSY | bus.WAKE_REQ;

  // Using >= rather than == lets a threshold lowered below the current
  // count start draining on the very next idle cycle. Activity in the
  // same cycle blocks the hit, so BUSY wins a tie with the threshold.
  always_comb begin
    drain_hit = 1'b0;
    wake_done = 1'b0;
    if ((state == RUN) && !active && (thresh != '0)) begin
      drain_hit = (idle_cnt >= (thresh - IDLE_W'(1)));
    end
    if (state == WAKE) begin
      wake_done = (settle_cnt >= SETTLE_W'(WAKE_DLY - 1));
    end
  end

  // The idle count only lives in RUN; leaving RUN, activity, scan or reset
  // all restart it from zero. The settle count only lives in WAKE.
  always_comb begin
    idle_clr   = RST | bus.SCAN_EN | (state != RUN) | active;
    idle_inc   = ~drain_hit;
    settle_clr = RST | bus.SCAN_EN | (state != WAKE);
    settle_inc = ~wake_done;
  end

  gf180mcu_fd_sc_mcu9t5v0__icgen_satcnt #(.W(IDLE_W)) u_idle_cnt (
    .CLK (CLK),
    .clr (idle_clr),
    .inc (idle_inc),
    .cnt (idle_cnt)
  );

  gf180mcu_fd_sc_mcu9t5v0__icgen_satcnt #(.W(SETTLE_W)) u_settle_cnt (
    .CLK (CLK),
    .clr (settle_clr),
    .inc (settle_inc),
    .cnt (settle_cnt)
  );

`ifdef GF180MCU_ICGEN_SEQ_STATS_EN
  logic gate_evt;

  // A gating event is the DRAIN->OFF step, i.e. DRAIN with no activity.
  assign gate_evt = (state == DRAIN) & ~active & ~bus.SCAN_EN & ~RST;

  gf180mcu_fd_sc_mcu9t5v0__icgen_satcnt #(.W(STATS_W)) u_gate_cnt (
    .CLK (CLK),
    .clr (RST),
    .inc (gate_evt),
    .cnt (GATE_CNT)
  );
`endif

  // State and all pin values are registered together so E only moves on
  // the rising edge and is stable well before the icgtn samples it.
  // Reset beats scan, scan beats the normal sequence.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= RUN;
      e_q     <= 1'b1;
      te_q    <= 1'b0;
      ack_q   <= 1'b1;
      gated_q <= 1'b0;
    end else begin
      te_q <= bus.SCAN_EN;
      if (bus.SCAN_EN) begin
        state   <= RUN;
        e_q     <= 1'b1;
        ack_q   <= 1'b1;
        gated_q <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            if (drain_hit) begin
              state <= DRAIN;
              ack_q <= 1'b0;
            end
          end
          DRAIN: begin
            if (active) begin
              state <= RUN;
              ack_q <= 1'b1;
            end else begin
              state   <= OFF;
              e_q     <= 1'b0;
              gated_q <= 1'b1;
            end
          end
          OFF: begin
            if (active) begin
              state   <= WAKE;
              e_q     <= 1'b1;
              gated_q <= 1'b0;
            end
          end
          WAKE: begin
            if (wake_done) begin
              state <= RUN;
              ack_q <= 1'b1;
            end
          end
          default: begin
            state   <= RUN;
            e_q     <= 1'b1;
            ack_q   <= 1'b1;
            gated_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.E        = e_q;
  assign bus.TE       = te_q;
  assign bus.WAKE_ACK = ack_q;
  assign bus.GATED    = gated_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__icgen_seq.sv
// Directed self-checking bench for the icgtn enable sequencer
// (IDLE_W = 4, WAKE_DLY = 2). Inputs change 1 ns after a rising edge and
// outputs are checked at that same point, after the edge has settled.
module tb_gf180mcu_fd_sc_mcu9t5v0__icgen_seq;

  logic CLK;
  logic RST;
  int   testCount;
  int   failCount;
  int   expGates;

`ifdef GF180MCU_ICGEN_SEQ_STATS_EN
  logic [7:0] gateCnt;
`endif

  gf180mcu_fd_sc_mcu9t5v0__icgen_seq_if #(.IDLE_W(4)) bus ();

  gf180mcu_fd_sc_mcu9t5v0__icgen_seq #(.IDLE_W(4), .WAKE_DLY(2)) dut (
    .CLK      (CLK),
    .RST      (RST),
`ifdef GF180MCU_ICGEN_SEQ_STATS_EN
    .GATE_CNT (gateCnt),
`endif
    .bus      (bus)
  );

  // Free-running 10 ns source clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish before 100000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic busy, input logic wake,
                               input logic scan, input logic [3:0] thresh);
    RST             = rst;
    bus.BUSY        = busy;
    bus.WAKE_REQ    = wake;
    bus.SCAN_EN     = scan;
    bus.IDLE_THRESH = thresh;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkPins(input string tag, input logic e, input logic te,
                           input logic ack, input logic gated);
    checkOutput({tag, ".E"},        32'(bus.E),        32'(e));
    checkOutput({tag, ".TE"},       32'(bus.TE),       32'(te));
    checkOutput({tag, ".WAKE_ACK"}, 32'(bus.WAKE_ACK), 32'(ack));
    checkOutput({tag, ".GATED"},    32'(bus.GATED),    32'(gated));
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    expGates  = 0;

    // Reset, then 4 idle cycles with threshold 4 gate the clock.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
    tick(2);
    checkPins("reset", 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
    tick(3);
    checkPins("t1.idle3", 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1);
    checkPins("t1.drain", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkPins("t1.off", 1'b0, 1'b0, 1'b0, 1'b1);
    expGates++;

    // One-cycle BUSY pulse in OFF: E next cycle, ack three cycles later.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
    tick(1);
    checkPins("t2.wake", 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
    tick(1);
    checkPins("t2.settle", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkPins("t2.ack", 1'b1, 1'b0, 1'b1, 1'b0);

    // Threshold 3, BUSY arriving in the DRAIN cycle cancels the gating.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
    tick(2);
    checkPins("t3.idle2", 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1);
    checkPins("t3.drain", 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
    tick(1);
    checkPins("t3.abort", 1'b1, 1'b0, 1'b1, 1'b0);

    // BUSY in the cycle the count would hit the threshold keeps RUN and
    // restarts the count.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
    tick(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
    tick(1);
    checkPins("t3.collide", 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
    tick(2);
    checkPins("t3.restart", 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1);
    checkPins("t3.drain2", 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
    tick(1);
    checkPins("t3.abort2", 1'b1, 1'b0, 1'b1, 1'b0);

    // Dropping the threshold below the running count drains next idle cycle.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd15);
    tick(5);
    checkPins("lower.idle5", 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
    tick(1);
    checkPins("lower.drain", 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
    tick(1);
    checkPins("lower.abort", 1'b1, 1'b0, 1'b1, 1'b0);

    // Threshold 0 never gates, however long the block stays idle.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 100; i++) begin
      tick(1);
      checkOutput("t4.E", 32'(bus.E), 32'd1);
      checkOutput("t4.GATED", 32'(bus.GATED), 32'd0);
    end

    // The idle count saturated at 15 meanwhile, so threshold 15 drains now.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd15);
    tick(1);
    checkPins("sat.drain", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkPins("sat.off", 1'b0, 1'b0, 1'b0, 1'b1);
    expGates++;

    // Scan in OFF forces E and TE high; afterwards idling restarts from 0.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
    tick(1);
    checkPins("t5.scan", 1'b1, 1'b1, 1'b1, 1'b0);
    tick(2);
    checkPins("t5.hold", 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
    tick(3);
    checkPins("t5.idle3", 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1);
    checkPins("t5.drain", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkPins("t5.off", 1'b0, 1'b0, 1'b0, 1'b1);
    expGates++;

    // Wake through WAKE_REQ held until ack, then gate once more.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd4);
    tick(1);
    checkPins("t6.wake", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkPins("t6.settle", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkPins("t6.ack", 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
    tick(4);
    checkPins("t6.drain", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkPins("t6.off", 1'b0, 1'b0, 1'b0, 1'b1);
    expGates++;

    // Reset in the middle of WAKE returns straight to RUN with ack high.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
    tick(1);
    checkPins("t6.wake2", 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef GF180MCU_ICGEN_SEQ_STATS_EN
    checkOutput("stats.count", 32'(gateCnt), 32'(expGates));
`endif
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
    tick(1);
    checkPins("t6.rst", 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef GF180MCU_ICGEN_SEQ_STATS_EN
    checkOutput("stats.clear", 32'(gateCnt), 32'd0);
`endif
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
    tick(1);
    checkPins("t6.post", 1'b1, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
